exp_flush_ctrl: RTL
===================

# exp_flush_ctrl

Parametrised exception/ERET flush controller for the MEM stage of the MIPS pipeline. It gates N write-enable channels from EX/MEM, captures EPC/cause/BD on an exception and holds a flush to the younger stages for a configurable number of cycles. It then issues a one-cycle PC redirect to the exception vector or to EPC on ERET. It sits between the EX/MEM pipeline register outputs and the register file, HI/LO, CP0 and data-memory write ports, and drives the IF-stage PC mux.

## Interface
Parameters:
- N_WE, 5, number of write-enable channels gated (mem, reg, hi, lo, cp0 by default)
- FLUSH_CYCLES, 2, cycles spent in FLUSH before redirect; legal range 1..15
- PC_W, 32, PC/EPC width
- CODE_W, 5, exception code width
- EXC_VECTOR, 32'hBFC00380, redirect target for exceptions

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- we_in  in  N_WE  write enables from EX/MEM
- exp_valid  in  1  exception detected in MEM this cycle
- exp_code  in  CODE_W  exception code, valid with exp_valid
- exp_pc  in  PC_W  PC of the faulting instruction
- in_delay_slot  in  1  faulting instruction is in a branch delay slot
- eret  in  1  ERET in MEM this cycle
- we_out  out  N_WE  gated write enables
- flush  out  1  flush IF/ID, ID/EX and EX/MEM registers
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  PC_W  redirect target
- epc  out  PC_W  captured EPC
- cause_code  out  CODE_W  captured exception code
- bd  out  1  captured branch-delay flag
- exl  out  1  exception level bit
- busy  out  1  state != IDLE

## Operation
The controller has three states: IDLE, FLUSH and REDIRECT, plus a 4-bit down-counter `cnt` and a target-select bit `tgt_epc`.

IDLE:
- we_out = we_in, flush = 0, unless an event is present.
- Exception event (exp_valid = 1):
  - Combinationally, we_out = 0 and flush = 1 in the same cycle.
  - If exl = 0: epc ← in_delay_slot ? exp_pc − 4 (mod 2^PC_W) : exp_pc; bd ← in_delay_slot; cause_code ← exp_code.
  - If exl = 1 (nested exception): epc and bd hold; cause_code still updates.
  - exl ← 1; tgt_epc ← 0; cnt ← FLUSH_CYCLES − 1; next state FLUSH.
- ERET event (eret = 1, exp_valid = 0):
  - we_out = 0, flush = 1.
  - exl ← 0; tgt_epc ← 1; cnt ← FLUSH_CYCLES − 1; next state FLUSH.
- exp_valid and eret together: the exception wins and eret is ignored.

FLUSH:
- we_out = 0, flush = 1.
- exp_valid and eret are ignored (wrong-path instructions).
- cnt = 0 → REDIRECT; otherwise cnt decrements.

REDIRECT:
- we_out = 0, flush = 1, redirect_valid = 1.
- redirect_pc = tgt_epc ? epc : EXC_VECTOR.
- Inputs are ignored. Next state is IDLE unconditionally.

redirect_pc outside REDIRECT: drives EXC_VECTOR, with redirect_valid = 0.

## Timing
- Reset (asynchronous, at any time including mid-FLUSH or mid-REDIRECT):
  - state = IDLE; cnt = 0; tgt_epc = 0.
  - epc = 0, cause_code = 0, bd = 0, exl = 0.
  - flush = 0, redirect_valid = 0, busy = 0; we_out follows we_in.
- Event accepted in IDLE at cycle T:
  - Gating at T has zero latency.
  - epc, cause_code, bd and exl reflect the capture from T+1.
  - FLUSH occupies T+1..T+FLUSH_CYCLES.
  - REDIRECT at T+FLUSH_CYCLES+1.
  - The earliest next accepted event is at T+FLUSH_CYCLES+2.
  - Default parameters: redirect at T+3; busy high T+1..T+3.
- flush is high for FLUSH_CYCLES+2 consecutive cycles per event: T through REDIRECT.
- EPC arithmetic is PC_W bits and wraps: exp_pc = 0 in a delay slot gives epc = 2^PC_W − 4.

## Test plan
- **Reset behaviour:** reset, then we_in = 5'b10110 with no event → we_out = 5'b10110 in the same cycle; epc = 0, exl = 0, busy = 0.
- **Exception capture and redirect:** exp_valid at T with exp_pc = 32'h80001000, exp_code = 5'h0C, in_delay_slot = 0 → at T, we_out = 0 and flush = 1. At T+1, epc = 32'h80001000, cause_code = 5'h0C, exl = 1. At T+3, redirect_valid = 1 with redirect_pc = 32'hBFC00380. At T+4, state is IDLE.
- **Delay slot:** exp_pc = 32'h80002004 with in_delay_slot = 1 → epc = 32'h80002000, bd = 1. A second test with exp_pc = 0 → epc = 32'hFFFFFFFC.
- **ERET round trip:** after the exception above, eret at T' → exl = 0 at T'+1. At T'+3, redirect_valid = 1 with redirect_pc = epc = 32'h80001000.
- **Nested and ignored events:**
  - exp_valid pulses during FLUSH → no state, epc or cause change.
  - exp_valid with exl = 1 in IDLE → epc and bd unchanged, cause_code updated.
  - exp_valid and eret together → exception path taken; exl stays 1.
- **Parameter and reset sweep:**
  - FLUSH_CYCLES = 1 → redirect at T+2.
  - FLUSH_CYCLES = 4 → redirect at T+5.
  - N_WE = 8 → all 8 channels gated.
  - resetn asserted during FLUSH → busy, flush and redirect_valid drop immediately; no redirect is ever issued.

Source files
------------

// File: rtl/exp_flush_ctrl_if.sv
// exp_flush_ctrl_if: bundle between the EX/MEM pipeline register outputs and
// the exception/ERET flush controller.
//
//   we_in          EX/MEM write enables (mem, reg, hi, lo, cp0, ...)
//   exp_valid      exception detected in MEM this cycle
//   exp_code       exception code, valid with exp_valid
//   exp_pc         PC of the faulting instruction
//   in_delay_slot  faulting instruction sits in a branch delay slot
//   eret           ERET in MEM this cycle
//   we_out         gated write enables toward RF, HI/LO, CP0 and data memory
//   flush          flush IF/ID, ID/EX and EX/MEM
//   redirect_valid one-cycle PC redirect strobe to the IF-stage PC mux
//   redirect_pc    redirect target
//   epc            captured EPC
//   cause_code     captured exception code
//   bd             captured branch-delay flag
//   exl            exception level bit
//   busy           controller is not idle
//
// master: the pipeline side that produces the events and consumes the gated
// enables and redirect.  slave: the controller itself.
interface exp_flush_ctrl_if #(
  parameter int N_WE   = 5,
  parameter int PC_W   = 32,
  parameter int CODE_W = 5
);
  logic [N_WE-1:0]   we_in;
  logic              exp_valid;
  logic [CODE_W-1:0] exp_code;
  logic [PC_W-1:0]   exp_pc;
  logic              in_delay_slot;
  logic              eret;

  logic [N_WE-1:0]   we_out;
  logic              flush;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [PC_W-1:0]   epc;
  logic [CODE_W-1:0] cause_code;
  logic              bd;
  logic              exl;
  logic              busy;

  modport master (
    output we_in, exp_valid, exp_code, exp_pc, in_delay_slot, eret,
    input  we_out, flush, redirect_valid, redirect_pc, epc, cause_code, bd, exl, busy
  );

  modport slave (
    input  we_in, exp_valid, exp_code, exp_pc, in_delay_slot, eret,
    output we_out, flush, redirect_valid, redirect_pc, epc, cause_code, bd, exl, busy
  );
endinterface

// File: rtl/exp_flush_ctrl.sv
// exp_flush_ctrl: MEM-stage exception/ERET flush controller.
//
// Gates the EX/MEM write enables, captures EPC/cause/BD when an exception is
// taken, holds flush to the younger stages for FLUSH_CYCLES cycles and then
// issues a one-cycle PC redirect to EXC_VECTOR (exception) or EPC (ERET).
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous, active-low reset
//   bus     exp_flush_ctrl_if.slave (events in, gated enables/redirect out)
//
// Parameters: N_WE, FLUSH_CYCLES (1..15), PC_W, CODE_W, EXC_VECTOR. The
// interface instance must use the same N_WE, PC_W and CODE_W.
module exp_flush_ctrl #(
  parameter int              N_WE         = 5,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              PC_W         = 32,
  parameter int              CODE_W       = 5,
  parameter logic [PC_W-1:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             resetn,
  exp_flush_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // Counter load: FLUSH is left when cnt reaches 0, so loading N-1 yields N
  // cycles in FLUSH.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              tgt_epc, tgt_epc_next;
  logic [PC_W-1:0]   epc_q, epc_next;
  logic [CODE_W-1:0] cause_q, cause_next;
  logic              bd_q, bd_next;
  logic              exl_q, exl_next;

  logic [N_WE-1:0]   we_out_c;
  logic              flush_c;
  logic              redirect_valid_c;
  logic [PC_W-1:0]   redirect_pc_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      tgt_epc <= 1'b0;
      epc_q   <= '0;
      cause_q <= '0;
      bd_q    <= 1'b0;
      exl_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      tgt_epc <= tgt_epc_next;
      epc_q   <= epc_next;
      cause_q <= cause_next;
      bd_q    <= bd_next;
      exl_q   <= exl_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    tgt_epc_next     = tgt_epc;
    epc_next         = epc_q;
    cause_next       = cause_q;
    bd_next          = bd_q;
    exl_next         = exl_q;
    we_out_c         = bus.we_in;
    flush_c          = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = EXC_VECTOR;

    unique case (state)
      ST_IDLE: begin
        // Exception has priority over a simultaneous ERET.
        if (bus.exp_valid) begin
          we_out_c = '0;
          flush_c  = 1'b1;
          // A nested exception (EXL already set) must not overwrite the
          // EPC/BD of the exception still being handled.
          if (!exl_q) begin
            epc_next = bus.in_delay_slot ? (bus.exp_pc - PC_W'(4)) : bus.exp_pc;
            bd_next  = bus.in_delay_slot;
          end
          cause_next   = bus.exp_code;
          exl_next     = 1'b1;
          tgt_epc_next = 1'b0;
          cnt_next     = CNT_INIT;
          state_next   = ST_FLUSH;
        end else if (bus.eret) begin
          we_out_c     = '0;
          flush_c      = 1'b1;
          exl_next     = 1'b0;
          tgt_epc_next = 1'b1;
          cnt_next     = CNT_INIT;
          state_next   = ST_FLUSH;
        end
      end

      // Events seen here come from wrong-path instructions and are dropped.
      ST_FLUSH: begin
        we_out_c = '0;
        flush_c  = 1'b1;
        if (cnt == 4'd0) begin
          state_next = ST_REDIRECT;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end

      ST_REDIRECT: begin
        we_out_c         = '0;
        flush_c          = 1'b1;
        redirect_valid_c = 1'b1;
        redirect_pc_c    = tgt_epc ? epc_q : EXC_VECTOR;
        state_next       = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.we_out         = we_out_c;
  assign bus.flush          = flush_c;
  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;
  assign bus.epc            = epc_q;
  assign bus.cause_code     = cause_q;
  assign bus.bd             = bd_q;
  assign bus.exl            = exl_q;
  assign bus.busy           = (state != ST_IDLE);

endmodule
